// File: rtl/mem_dbus_ctrl_if.sv
// rtl/mem_dbus_ctrl_if.sv - data bus request/response interface between the MEM-stage controller and memory
//
// Signals:
//   bus_en       request valid (controller -> memory)
//   bus_wen      byte write enables, 0000 = load
//   bus_addr     physical byte address
//   bus_wdata    store data
//   bus_addr_ok  request accepted (memory -> controller)
//   bus_data_ok  response valid
//   bus_rdata    load data, qualified by bus_data_ok
// Modports: master = controller side, slave = memory side.

interface mem_dbus_ctrl_if;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_en, bus_wen, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_en, bus_wen, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_dbus_ctrl.sv
// rtl/mem_dbus_ctrl.sv - MEM-stage data bus controller: one outstanding access, flush draining, load-data hold
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   m_en_i          MEM-stage data access request
//   m_wen_i         byte write enables (0000 = load)
//   m_vaddr_i       virtual byte address
//   m_wdata_i       store data
//   m_excp_i        instruction carries an exception, access suppressed
//   flush_i         pipeline flush
//   pipe_stall_i    MEM/WB register held by another stall source
//   bus             data bus, master side
//   m_rdata_o       load data returned to the MEM stage
//   stall_req_o     stall request to pipeline control

module mem_dbus_ctrl #(
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_en_i,
    input  logic [3:0]             m_wen_i,
    input  logic [31:0]            m_vaddr_i,
    input  logic [31:0]            m_wdata_i,
    input  logic                   m_excp_i,
    input  logic                   flush_i,
    input  logic                   pipe_stall_i,
    mem_dbus_ctrl_if.master        bus,
    output logic [31:0]            m_rdata_o,
    output logic                   stall_req_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wen_q,   wen_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_valid;
    logic [31:0] paddr;

    // Reserved parameter; tied off so it carries no function.
    logic unused_cfg;
    assign unused_cfg = (RESET_PC_UNUSED != 0);

    assign req_valid = m_en_i & ~m_excp_i & ~flush_i;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity mapped.
    assign paddr = (m_vaddr_i[31:30] == 2'b10) ? {3'b000, m_vaddr_i[28:0]} : m_vaddr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wen_q   <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = m_wen_i;
                    addr_d  = paddr;
                    wdata_d = m_wdata_i;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (bus.bus_addr_ok) begin
                    if (bus.bus_data_ok) begin
                        // Zero-wait response: under flush the data is simply dropped.
                        if (flush_i) begin
                            state_d = S_IDLE;
                        end else begin
                            rdata_d = bus.bus_rdata;
                            state_d = S_HOLD;
                        end
                    end else begin
                        // Accepted but not answered: a flush must still wait it out.
                        state_d = flush_i ? S_DRAIN : S_DATA;
                    end
                end else if (flush_i) begin
                    // Not yet accepted, so the request can be withdrawn outright.
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (bus.bus_data_ok) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        rdata_d = bus.bus_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end

            S_HOLD: begin
                // Keep the result until the MEM/WB register actually advances.
                if (!pipe_stall_i || flush_i) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (bus.bus_data_ok) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.bus_en    = (state_q == S_ADDR);
    assign bus.bus_wen   = wen_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign m_rdata_o   = rdata_q;
    assign stall_req_o = m_en_i & ~m_excp_i & (state_q != S_HOLD);

endmodule
